// File: rtl/mips_cpu_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle controller: FSM states, opcodes and ALUOp codes.
// Also used by the ALU control decoder.
package mips_cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [3:0] ALUOP_ADD     = 4'b0000;
    localparam logic [3:0] ALUOP_SUB     = 4'b0001;
    localparam logic [3:0] ALUOP_RTYPE   = 4'b0010;
    localparam logic [3:0] ALUOP_AND     = 4'b0100;
    localparam logic [3:0] ALUOP_OR      = 4'b0101;
    localparam logic [3:0] ALUOP_XOR     = 4'b0110;
    localparam logic [3:0] ALUOP_SLT     = 4'b0111;
    localparam logic [3:0] ALUOP_BNE     = 4'b1000;
    localparam logic [3:0] ALUOP_BGTZ    = 4'b1001;
    localparam logic [3:0] ALUOP_BLEZ    = 4'b1010;
    localparam logic [3:0] ALUOP_BRANCHZ = 4'b1011;

endpackage

// File: rtl/mips_cpu_ctrl_opdecode.sv
// Combinational opcode classifier: ALUOp plus memory/load/register-write attributes.
module mips_cpu_ctrl_opdecode
    import mips_cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] alu_op,
    output logic       is_mem,
    output logic       is_load,
    output logic       writes_reg
);

    always_comb begin
        alu_op     = ALUOP_ADD;
        is_mem     = 1'b0;
        is_load    = 1'b0;
        writes_reg = 1'b0;
        case (opcode)
            OP_LW:      begin is_mem = 1'b1; is_load = 1'b1; end
            OP_SW:      is_mem = 1'b1;
            OP_ADDIU,
            OP_LUI,
            OP_JAL:     writes_reg = 1'b1;
            OP_J:       alu_op = ALUOP_ADD;
            OP_BEQ:     alu_op = ALUOP_SUB;
            OP_SPECIAL: begin alu_op = ALUOP_RTYPE; writes_reg = 1'b1; end
            OP_ANDI:    begin alu_op = ALUOP_AND;   writes_reg = 1'b1; end
            OP_ORI:     begin alu_op = ALUOP_OR;    writes_reg = 1'b1; end
            OP_XORI:    begin alu_op = ALUOP_XOR;   writes_reg = 1'b1; end
            OP_SLTI,
            OP_SLTIU:   begin alu_op = ALUOP_SLT;   writes_reg = 1'b1; end
            OP_BNE:     alu_op = ALUOP_BNE;
            OP_BGTZ:    alu_op = ALUOP_BGTZ;
            OP_BLEZ:    alu_op = ALUOP_BLEZ;
            OP_REGIMM:  alu_op = ALUOP_BRANCHZ;
            // Unknown opcodes fall through as a NOP that still commits the PC.
            default:    ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_ctrl_fsm.sv
// Multicycle FETCH/EXEC/MEM/WB sequencer with waitrequest stalls, halt and optional stall timeout.
// Define MIPS_CPU_CTRL_PERF_EN to add retired_cnt/stall_cnt performance counters.
module mips_cpu_ctrl_fsm
    import mips_cpu_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int WAIT_CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  instr_opcode,
    input  logic        mem_waitrequest,
    input  logic        next_pc_zero,
    output logic [3:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        active,
`ifdef MIPS_CPU_CTRL_PERF_EN
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        timeout
);

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]           LIMIT_U = WAIT_LIMIT;

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;

    logic [3:0] dec_alu_op;
    logic       dec_is_mem, dec_is_load, dec_writes_reg;
    logic [3:0] alu_op_c;
    logic       mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic       stall_c;

    mips_cpu_ctrl_opdecode u_opdecode (
        .opcode     (instr_opcode),
        .alu_op     (dec_alu_op),
        .is_mem     (dec_is_mem),
        .is_load    (dec_is_load),
        .writes_reg (dec_writes_reg)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        alu_op_c    = ALUOP_ADD;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        stall_c     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_waitrequest) begin
                    stall_c = 1'b1;
                end else begin
                    ir_write_c = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op_c = dec_alu_op;
                if (dec_is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    reg_write_c = dec_writes_reg;
                    pc_write_c  = 1'b1;
                    state_d     = next_pc_zero ? ST_HALT : ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_read_c  = dec_is_load;
                mem_write_c = ~dec_is_load;
                if (mem_waitrequest) begin
                    stall_c = 1'b1;
                end else if (dec_is_load) begin
                    state_d = ST_WB;
                end else begin
                    pc_write_c = 1'b1;
                    state_d    = next_pc_zero ? ST_HALT : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                state_d     = next_pc_zero ? ST_HALT : ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase

        // Counter holds the number of earlier consecutive stall cycles in this access.
        if (stall_c) begin
            if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (WAIT_LIMIT != 0 && (32'(wait_cnt_q) + 32'd1) >= LIMIT_U) begin
                state_d   = ST_HALT;
                timeout_d = 1'b1;
            end
        end else begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Strobes are forced low while reset is asserted so no access leaks out mid-reset.
    assign alu_op    = rst_n ? alu_op_c : ALUOP_ADD;
    assign mem_read  = rst_n & mem_read_c;
    assign mem_write = rst_n & mem_write_c;
    assign ir_write  = rst_n & ir_write_c;
    assign pc_write  = rst_n & pc_write_c;
    assign reg_write = rst_n & reg_write_c;
    assign active    = (state_q != ST_HALT);
    assign timeout   = timeout_q;

`ifdef MIPS_CPU_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stalls_q, stalls_d;

    always_comb begin
        retired_d = retired_q + {31'd0, pc_write_c};
        stalls_d  = stalls_q + {31'd0, stall_c};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
            stalls_q  <= '0;
        end else begin
            retired_q <= retired_d;
            stalls_q  <= stalls_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stalls_q;
`endif

endmodule

// File: tb/tb_mips_cpu_ctrl_fsm.sv
// Scoreboard bench: an instruction-level timeline model queues expected per-cycle outputs,
// a negedge monitor pops and compares them against the controller.
module tb_mips_cpu_ctrl_fsm;

    localparam int LIMIT = 4;

    localparam logic [5:0] O_SPECIAL = 6'b000000, O_REGIMM = 6'b000001, O_J    = 6'b000010;
    localparam logic [5:0] O_JAL     = 6'b000011, O_BEQ    = 6'b000100, O_BNE  = 6'b000101;
    localparam logic [5:0] O_BLEZ    = 6'b000110, O_BGTZ   = 6'b000111, O_ADDIU = 6'b001001;
    localparam logic [5:0] O_SLTI    = 6'b001010, O_SLTIU  = 6'b001011, O_ANDI = 6'b001100;
    localparam logic [5:0] O_ORI     = 6'b001101, O_XORI   = 6'b001110, O_LUI  = 6'b001111;
    localparam logic [5:0] O_LW      = 6'b100011, O_SW     = 6'b101011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] instr_opcode = 6'd0;
    logic       mem_waitrequest = 1'b0;
    logic       next_pc_zero = 1'b0;
    logic [3:0] alu_op;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write, active, timeout;
`ifdef MIPS_CPU_CTRL_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    mips_cpu_ctrl_fsm #(.WAIT_LIMIT(LIMIT), .WAIT_CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_opcode    (instr_opcode),
        .mem_waitrequest (mem_waitrequest),
        .next_pc_zero    (next_pc_zero),
        .alu_op          (alu_op),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .ir_write        (ir_write),
        .pc_write        (pc_write),
        .reg_write       (reg_write),
        .active          (active),
`ifdef MIPS_CPU_CTRL_PERF_EN
        .retired_cnt     (retired_cnt),
        .stall_cnt       (stall_cnt),
`endif
        .timeout         (timeout)
    );

    typedef struct {
        logic [3:0]  alu_op;
        logic        mr, mw, irw, pcw, rw, act, to;
        bit          chk;
        int unsigned ret, stl;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          halted = 0;
    bit          to_m = 0;
    int unsigned ret_m = 0;
    int unsigned stl_m = 0;

    logic [5:0] op_pool [20] = '{O_SPECIAL, O_REGIMM, O_J, O_JAL, O_BEQ, O_BNE, O_BLEZ, O_BGTZ,
                                 O_ADDIU, O_SLTI, O_SLTIU, O_ANDI, O_ORI, O_XORI, O_LUI,
                                 O_LW, O_SW, 6'b010000, 6'b111111, 6'b100000};

    function automatic logic [3:0] ref_alu(input logic [5:0] op);
        case (op)
            O_BEQ:           return 4'd1;
            O_SPECIAL:       return 4'd2;
            O_ANDI:          return 4'd4;
            O_ORI:           return 4'd5;
            O_XORI:          return 4'd6;
            O_SLTI, O_SLTIU: return 4'd7;
            O_BNE:           return 4'd8;
            O_BGTZ:          return 4'd9;
            O_BLEZ:          return 4'd10;
            O_REGIMM:        return 4'd11;
            default:         return 4'd0;
        endcase
    endfunction

    function automatic logic ref_wr(input logic [5:0] op);
        return (op == O_SPECIAL || op == O_ADDIU || op == O_ANDI || op == O_ORI ||
                op == O_XORI || op == O_SLTI || op == O_SLTIU || op == O_LUI || op == O_JAL);
    endfunction

    function automatic exp_t base(input string tag);
        exp_t e;
        e.alu_op = 4'd0;
        e.mr = 0; e.mw = 0; e.irw = 0; e.pcw = 0; e.rw = 0;
        e.act = !halted;
        e.to  = to_m;
        e.chk = 1;
        e.ret = ret_m;
        e.stl = stl_m;
        e.tag = tag;
        return e;
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, input logic wr, input logic npz,
                         input exp_t e);
        @(posedge clk);
        #1;
        rst_n = r;
        instr_opcode = op;
        mem_waitrequest = wr;
        next_pc_zero = npz;
        exp_q.push_back(e);
    endtask

    task automatic commit(input logic npz);
        ret_m++;
        if (npz) halted = 1;
    endtask

    task automatic wait_phase(input int waits, input bit in_fetch, input bit is_rd,
                              input logic [5:0] op, output bit died);
        exp_t e;
        died = 0;
        for (int k = 1; k <= waits; k++) begin
            e = base(in_fetch ? "fetch_wait" : "mem_wait");
            e.mr = is_rd;
            e.mw = !is_rd;
            drive(1'b1, in_fetch ? 6'($urandom) : op, 1'b1, 1'($urandom), e);
            stl_m++;
            if (LIMIT != 0 && k == LIMIT) begin
                halted = 1;
                to_m = 1;
                died = 1;
                return;
            end
        end
    endtask

    task automatic fetch_exec(input logic [5:0] op, input int wf, output bit died);
        exp_t e;
        wait_phase(wf, 1, 1, op, died);
        if (died) return;
        e = base("fetch");
        e.mr = 1; e.irw = 1;
        drive(1'b1, 6'($urandom), 1'b0, 1'($urandom), e);
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input logic npz);
        exp_t e;
        bit died;
        fetch_exec(op, wf, died);
        if (died) return;
        e = base("exec");
        e.alu_op = ref_alu(op);
        if (op == O_LW || op == O_SW) begin
            drive(1'b1, op, 1'($urandom), 1'($urandom), e);
            wait_phase(wm, 0, op == O_LW, op, died);
            if (died) return;
            if (op == O_SW) begin
                e = base("sw_done");
                e.mw = 1; e.pcw = 1;
                drive(1'b1, op, 1'b0, npz, e);
                commit(npz);
            end else begin
                e = base("lw_done");
                e.mr = 1;
                drive(1'b1, op, 1'b0, 1'($urandom), e);
                e = base("wb");
                e.rw = 1; e.pcw = 1;
                drive(1'b1, op, 1'($urandom), npz, e);
                commit(npz);
            end
        end else begin
            e.rw = ref_wr(op);
            e.pcw = 1;
            drive(1'b1, op, 1'($urandom), npz, e);
            commit(npz);
        end
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 6'($urandom), 1'($urandom), 1'($urandom), base("halt"));
        end
    endtask

    task automatic do_reset();
        exp_t e;
        e = base("reset");
        e.chk = 0;
        drive(1'b0, 6'($urandom), 1'($urandom), 1'($urandom), e);
        halted = 0; to_m = 0; ret_m = 0; stl_m = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit ok;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            ok = (alu_op === e.alu_op) && (mem_read === e.mr) && (mem_write === e.mw) &&
                 (ir_write === e.irw) && (pc_write === e.pcw) && (reg_write === e.rw);
            if (e.chk) ok = ok && (active === e.act) && (timeout === e.to);
`ifdef MIPS_CPU_CTRL_PERF_EN
            if (e.chk) ok = ok && (retired_cnt === e.ret) && (stall_cnt === e.stl);
`endif
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s @%0t: got alu=%h rd=%b wr=%b ir=%b pc=%b rf=%b act=%b to=%b, expected alu=%h rd=%b wr=%b ir=%b pc=%b rf=%b act=%b to=%b (status checked=%0d)",
                         e.tag, $time, alu_op, mem_read, mem_write, ir_write, pc_write, reg_write,
                         active, timeout, e.alu_op, e.mr, e.mw, e.irw, e.pcw, e.rw, e.act, e.to, e.chk);
            end
        end
    end

    initial begin
        bit died;
        int wf, wm;
        logic [5:0] op;

        do_reset();
        do_reset();
        // Directed cases from the plan.
        run_instr(O_ADDIU, 0, 0, 1'b0);
        run_instr(O_LW, 0, 3, 1'b0);
        run_instr(O_BNE, 0, 0, 1'b0);
        run_instr(O_REGIMM, 1, 0, 1'b0);
        run_instr(O_SW, 0, 0, 1'b1);
        halt_cycles(12);
        do_reset();
        // Reset landing in the middle of a store stall.
        fetch_exec(O_SW, 0, died);
        drive(1'b1, O_SW, 1'b0, 1'b0, base("exec"));
        wait_phase(2, 0, 0, O_SW, died);
        do_reset();
        run_instr(O_ADDIU, 0, 0, 1'b0);
        // Waitrequest stuck in FETCH trips the timeout.
        run_instr(O_ADDIU, 6, 0, 1'b0);
        halt_cycles(4);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            op = op_pool[$urandom_range(0, 19)];
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
            wm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            run_instr(op, wf, wm, 1'($urandom_range(0, 11) == 0));
            if (halted) begin
                halt_cycles($urandom_range(1, 4));
                do_reset();
            end
        end

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
